// File: rtl/endscreen_pixel_fetch.sv
// End-screen pixel fetch: maps the VGA raster position onto a down-scaled
// index ROM, returns the palette index three clocks later with a matching
// blank signal, and runs a frame-paced fade-in for the end-screen image.
module endscreen_pixel_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int FADE_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank_n,
    input  logic        vsync,
    input  logic        start,
    output logic [14:0] rom_addr,
    input  logic [2:0]  rom_q,
    output logic [2:0]  index,
    output logic        blank_out,
    output logic [3:0]  fade_level,
    output logic        fade_done
);

    // The visible screen is the image blown up by 2^SCALE_SHIFT in each axis.
    localparam logic [10:0] SCREEN_W = 11'(IMG_W << SCALE_SHIFT);
    localparam logic [10:0] SCREEN_H = 11'(IMG_H << SCALE_SHIFT);
    localparam logic [1:0]  LAST_FRAME = 2'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD
    } fade_state_e;

    // Pixel pipeline registers
    logic [14:0] rom_addr_q, rom_addr_d;
    logic        rng_s1_q, rng_s1_d;
    logic        rng_s2_q, rng_s2_d;
    logic        blank_s1_q, blank_s1_d;
    logic        blank_s2_q, blank_s2_d;
    logic        blank_s3_q, blank_s3_d;
    logic [2:0]  index_q, index_d;

    // Fade controller registers
    fade_state_e state_q, state_d;
    logic [1:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  level_q, level_d;
    logic        done_q, done_d;
    logic        vsync_prev_q, vsync_prev_d;

    logic        in_range;
    logic [14:0] img_row;
    logic [14:0] img_col;
    logic [14:0] addr_calc;
    logic        vsync_edge;

    // Address generation and the delay line that keeps index, in-range and blank aligned
    always_comb begin
        in_range   = blank_n && ({1'b0, draw_x} < SCREEN_W) && ({1'b0, draw_y} < SCREEN_H);
        img_row    = 15'(draw_y >> SCALE_SHIFT);
        img_col    = 15'(draw_x >> SCALE_SHIFT);
        addr_calc  = img_row * 15'(IMG_W) + img_col;
        rom_addr_d = in_range ? addr_calc : 15'd0;
        rng_s1_d   = in_range;
        rng_s2_d   = rng_s1_q;
        blank_s1_d = blank_n;
        blank_s2_d = blank_s1_q;
        blank_s3_d = blank_s2_q;
        index_d    = rng_s2_q ? rom_q : 3'd0;
    end

    // Pixel pipeline state; reset zeroes everything so the screen starts black
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q <= '0;
            rng_s1_q   <= 1'b0;
            rng_s2_q   <= 1'b0;
            blank_s1_q <= 1'b0;
            blank_s2_q <= 1'b0;
            blank_s3_q <= 1'b0;
            index_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            rng_s1_q   <= rng_s1_d;
            rng_s2_q   <= rng_s2_d;
            blank_s1_q <= blank_s1_d;
            blank_s2_q <= blank_s2_d;
            blank_s3_q <= blank_s3_d;
            index_q    <= index_d;
        end
    end

    // Fade next-state logic; a start pulse always wins over a coincident frame edge
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        level_d      = level_q;
        done_d       = done_q;
        vsync_edge   = vsync && !vsync_prev_q;
        vsync_prev_d = vsync;
        case (state_q)
            IDLE: begin
                level_d = 4'd0;
                done_d  = 1'b0;
                if (start) begin
                    state_d     = RAMP;
                    frame_cnt_d = 2'd0;
                end
            end
            RAMP: begin
                done_d = 1'b0;
                if (start) begin
                    level_d     = 4'd0;
                    frame_cnt_d = 2'd0;
                end else if (vsync_edge) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        frame_cnt_d = 2'd0;
                        level_d     = level_q + 4'd1;
                        if (level_q == 4'd14) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 2'd1;
                    end
                end
            end
            HOLD: begin
                level_d = 4'd15;
                done_d  = 1'b1;
                if (start) begin
                    state_d     = RAMP;
                    level_d     = 4'd0;
                    frame_cnt_d = 2'd0;
                    done_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                level_d     = 4'd0;
                frame_cnt_d = 2'd0;
                done_d      = 1'b0;
            end
        endcase
    end

    // Fade state; previous-vsync resets high so a high vsync at release is not an edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            level_q      <= '0;
            done_q       <= 1'b0;
            vsync_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            level_q      <= level_d;
            done_q       <= done_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign index      = index_q;
    assign blank_out  = blank_s3_q;
    assign fade_level = level_q;
    assign fade_done  = done_q;

endmodule

// File: tb/tb_endscreen_pixel_fetch.sv
// Self-checking bench for endscreen_pixel_fetch: table-driven pixel stream
// checked through a scoreboard, plus hand-written fade and reset sequences.
module tb_endscreen_pixel_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic        blank_n = 1'b0;
    logic        vsync = 1'b0;
    logic        start = 1'b0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_q = '0;
    logic [2:0]  index;
    logic        blank_out;
    logic [3:0]  fade_level;
    logic        fade_done;

    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        bn;
        logic [14:0] addr;
        logic [2:0]  idx;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic       bo;
        int         id;
    } exp_t;

    vec_t        vecs[12];
    exp_t        q_out[$];
    logic [14:0] q_addr[$];
    int          q_addr_id[$];

    endscreen_pixel_fetch dut (
        .Clk(Clk), .Reset(Reset), .draw_x(draw_x), .draw_y(draw_y),
        .blank_n(blank_n), .vsync(vsync), .start(start), .rom_addr(rom_addr),
        .rom_q(rom_q), .index(index), .blank_out(blank_out),
        .fade_level(fade_level), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    // ROM contents: location 0 holds 7, elsewhere a mix of the low address bits
    function automatic logic [2:0] rom_fn(input logic [14:0] a);
        if (a == 15'd0) return 3'd7;
        return a[2:0] ^ a[5:3];
    endfunction

    // Synchronous index ROM: data valid one edge after the address
    always @(posedge Clk) rom_q <= rom_fn(rom_addr);

    task automatic checkOutput(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (item %0d): got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    // At each falling edge: compare what has reached the outputs, then drive the next pixel
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic bn,
                                 input logic [14:0] ea, input logic [2:0] ei, input int id);
        exp_t e;
        @(negedge Clk);
        if (q_addr.size() >= 1)
            checkOutput("rom_addr", q_addr_id.pop_front(), 32'(rom_addr), 32'(q_addr.pop_front()));
        if (q_out.size() >= 3) begin
            e = q_out.pop_front();
            checkOutput("index", e.id, 32'(index), 32'(e.idx));
            checkOutput("blank_out", e.id, 32'(blank_out), 32'(e.bo));
        end
        draw_x  = x;
        draw_y  = y;
        blank_n = bn;
        q_addr.push_back(ea);
        q_addr_id.push_back(id);
        q_out.push_back('{idx: ei, bo: bn, id: id});
    endtask

    task automatic vsyncEdge();
        @(negedge Clk) vsync = 1'b1;
        @(negedge Clk) vsync = 1'b0;
    endtask

    task automatic startPulse();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{x: 10'd4,    y: 10'd4,    bn: 1'b1, addr: 15'd161,   idx: 3'd5};
        vecs[1]  = '{x: 10'd639,  y: 10'd479,  bn: 1'b1, addr: 15'd19199, idx: 3'd0};
        vecs[2]  = '{x: 10'd700,  y: 10'd10,   bn: 1'b1, addr: 15'd0,     idx: 3'd0};
        vecs[3]  = '{x: 10'd10,   y: 10'd10,   bn: 1'b0, addr: 15'd0,     idx: 3'd0};
        vecs[4]  = '{x: 10'd0,    y: 10'd0,    bn: 1'b1, addr: 15'd0,     idx: 3'd7};
        vecs[5]  = '{x: 10'd100,  y: 10'd50,   bn: 1'b1, addr: 15'd1945,  idx: 3'd2};
        vecs[6]  = '{x: 10'd3,    y: 10'd7,    bn: 1'b1, addr: 15'd160,   idx: 3'd4};
        vecs[7]  = '{x: 10'd640,  y: 10'd0,    bn: 1'b1, addr: 15'd0,     idx: 3'd0};
        vecs[8]  = '{x: 10'd0,    y: 10'd480,  bn: 1'b1, addr: 15'd0,     idx: 3'd0};
        vecs[9]  = '{x: 10'd319,  y: 10'd239,  bn: 1'b1, addr: 15'd9519,  idx: 3'd2};
        vecs[10] = '{x: 10'd1023, y: 10'd1023, bn: 1'b1, addr: 15'd0,     idx: 3'd0};
        vecs[11] = '{x: 10'd8,    y: 10'd0,    bn: 1'b1, addr: 15'd2,     idx: 3'd2};

        // Reset asserted before any rising clock edge
        #1 Reset = 1'b1;
        #2;
        checkOutput("reset rom_addr", 0, 32'(rom_addr), 0);
        checkOutput("reset index", 0, 32'(index), 0);
        checkOutput("reset blank_out", 0, 32'(blank_out), 0);
        checkOutput("reset fade_level", 0, 32'(fade_level), 0);
        checkOutput("reset fade_done", 0, 32'(fade_done), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Back-to-back pixel stream, one per clock, then blank pixels to drain the pipe
        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].bn, vecs[i].addr, vecs[i].idx, i);
        for (int i = 0; i < 3; i++)
            applyStimulus(10'd0, 10'd0, 1'b0, 15'd0, 3'd0, 100 + i);
        q_out.delete();
        q_addr.delete();
        q_addr_id.delete();

        // Fade-in from IDLE: level steps every fourth frame, HOLD at frame 60
        vsyncEdge();
        checkOutput("idle ignores vsync", 0, 32'(fade_level), 0);
        startPulse();
        checkOutput("start level", 0, 32'(fade_level), 0);
        for (int k = 1; k <= 60; k++) begin
            vsyncEdge();
            checkOutput("ramp level", k, 32'(fade_level), 32'(k / 4));
            checkOutput("ramp done", k, 32'(fade_done), (k == 60) ? 1 : 0);
        end
        for (int k = 61; k <= 64; k++) begin
            vsyncEdge();
            checkOutput("hold level", k, 32'(fade_level), 15);
            checkOutput("hold done", k, 32'(fade_done), 1);
        end

        // Start from HOLD restarts the ramp
        startPulse();
        checkOutput("hold restart level", 0, 32'(fade_level), 0);
        checkOutput("hold restart done", 0, 32'(fade_done), 0);

        // Start coincident with a frame edge that would have bumped level 9 to 10
        for (int k = 1; k <= 39; k++) vsyncEdge();
        checkOutput("pre-collision level", 39, 32'(fade_level), 9);
        @(negedge Clk);
        start = 1'b1;
        vsync = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        vsync = 1'b0;
        checkOutput("collision level", 0, 32'(fade_level), 0);
        for (int k = 1; k <= 4; k++) begin
            vsyncEdge();
            checkOutput("post-collision level", k, 32'(fade_level), 32'(k / 4));
        end
        vsyncEdge();
        checkOutput("mid-ramp level", 5, 32'(fade_level), 1);

        // Asynchronous reset between clock edges while ramping
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async reset level", 0, 32'(fade_level), 0);
        checkOutput("async reset done", 0, 32'(fade_done), 0);
        checkOutput("async reset index", 0, 32'(index), 0);
        checkOutput("async reset blank_out", 0, 32'(blank_out), 0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 5; k++) vsyncEdge();
        checkOutput("idle after reset", 0, 32'(fade_level), 0);
        startPulse();
        for (int k = 1; k <= 4; k++) vsyncEdge();
        checkOutput("ramp after reset", 4, 32'(fade_level), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/endscreen_pixel_fetch.md
ENDSCREEN_PIXEL_FETCH -- requirements
Module: endscreen_pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_W, 160, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, 120, source image height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, 2, log2 of screen-to-image scale (640x480 -> 160x120).
REQ-004 SHALL have parameter FADE_FRAMES, 4, frames per fade step.
REQ-005 SHALL have port Clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port draw_x  input  10  current screen column from VGA controller.
REQ-008 SHALL have port draw_y  input  10  current screen row from VGA controller.
REQ-009 SHALL have port blank_n  input  1  1 = active video.
REQ-010 SHALL have port vsync  input  1  VGA vertical sync; rising edge marks a frame.
REQ-011 SHALL have port start  input  1  single-cycle pulse; begin or restart fade-in.
REQ-012 SHALL have port rom_addr  output  15  address to end-screen index ROM.
REQ-013 SHALL have port rom_q  input  3  ROM data, valid one Clk edge after rom_addr.
REQ-014 SHALL have port index  output  3  palette index to the end-screen palette lookup.
REQ-015 SHALL have port blank_out  output  1  blank_n delayed to align with index.
REQ-016 SHALL have port fade_level  output  4  brightness 0 (black) to 15 (full).
REQ-017 SHALL have port fade_done  output  1  1 while fade_level held at 15.

Function
REQ-018 SHALL compute in_range = blank_n AND draw_x < 640 AND draw_y < 480.
REQ-019 SHALL compute address = (draw_y >> SCALE_SHIFT) * IMG_W + (draw_x >> SCALE_SHIFT), 15-bit, no truncation (max 19199).
REQ-020 SHALL register rom_addr at the edge sampling the inputs; rom_addr = 0 when in_range = 0.
REQ-021 SHALL register index at the edge after rom_q becomes valid; total latency draw_x/draw_y -> index = 3 rising edges.
REQ-022 SHALL force index = 0 when the delayed in_range for that pixel is 0, regardless of rom_q.
REQ-023 SHALL delay blank_n and in_range through a 3-stage shift so blank_out aligns exactly with index.
REQ-024 SHALL accept a new pixel every cycle; no stalls, no backpressure.
REQ-025 SHALL detect vsync rising edge via a registered previous-vsync bit (reset value 1, so vsync high at reset release produces no edge).
REQ-026 SHALL implement fade FSM with states IDLE, RAMP, HOLD.
REQ-027 IDLE: fade_level = 0, fade_done = 0; start -> RAMP with fade_level 0, frame counter 0.
REQ-028 RAMP: each vsync edge increments a 2-bit frame counter; on edge where counter = FADE_FRAMES-1, counter wraps to 0 and fade_level increments.
REQ-029 RAMP: when fade_level increments to 15, transition to HOLD.
REQ-030 HOLD: fade_level = 15, fade_done = 1; vsync edges ignored; start -> RAMP with fade_level 0, counter 0.
REQ-031 start in RAMP SHALL restart (fade_level 0, counter 0, remain RAMP).
REQ-032 start coincident with vsync edge SHALL take priority; no increment that cycle.
REQ-033 Full ramp from start to HOLD SHALL take exactly 15 * FADE_FRAMES vsync edges.

Reset
REQ-034 Reset SHALL asynchronously clear rom_addr, index, blank_out, pipeline delay bits, frame counter, fade_level, fade_done to 0 and FSM to IDLE, without a clock edge.
REQ-035 After Reset deasserts, first valid index SHALL appear 3 edges after the first sampled in-range pixel.

Verification
REQ-036 Assert Reset with no clock -> all outputs 0, FSM IDLE.
REQ-037 draw_x=4, draw_y=4, blank_n=1, rom_q=5 -> rom_addr=161 after edge 1; index=5, blank_out=1 after edge 3.
REQ-038 draw_x=639, draw_y=479 -> rom_addr=19199; draw_x=700 or blank_n=0 -> rom_addr=0, index=0 with rom_q=7.
REQ-039 start, then 60 vsync edges -> fade_level steps every 4th edge, reaches 15 on edge 60, fade_done=1; further edges no change.
REQ-040 start in same cycle as vsync edge at fade_level 9 -> fade_level 0, counter 0, state RAMP.
REQ-041 Reset pulsed mid-RAMP between clock edges -> fade_level 0, fade_done 0 immediately; FSM IDLE.
